bin2ascii_str: RTL and testbench

Sequential binary-to-decimal ASCII string serializer. It accepts one unsigned WIDTH-bit measurement word through a valid/ready handshake and converts it to DIGITS BCD digits with a shift-add-3 (double dabble) engine, one bit per clock. It then streams the digits as ASCII characters ('0'..'9'), most significant digit first, optionally followed by a terminator byte. It sits between the measurement datapath and the UART transmit byte stream, and generalises the single-digit combinational ASCII mapping to full multi-digit numbers.

---
 rtl/bin2ascii_str.sv | 199 +++++++++++++++++++
 tb/tb_bin2ascii_str.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bin2ascii_str.sv
// Sequential binary-to-decimal ASCII string serializer (double dabble, one bit per clock).
// Optional build macro BIN2ASCII_LZS_EN enables leading-zero suppression.
module bin2ascii_str #(
    parameter int          WIDTH     = 16,
    parameter int          DIGITS    = 5,
    parameter int          SEND_TERM = 1,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(DIGITS - 1);
    localparam logic          TERM_EN  = (SEND_TERM != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_PREP = 2'd2,
        S_SEND = 2'd3
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // ASCII character for BCD nibble idx.
    function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [IW-1:0] idx);
        logic [3:0] nib;
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib = b[4*i +: 4];
            end else begin
                nib = nib;
            end
        end
        return 8'h30 + {4'h0, nib};
    endfunction

    state_t            state_r, state_n;
    logic [WIDTH-1:0]  bin_r, bin_n;
    logic [BW-1:0]     bcd_r, bcd_n;
    logic [CW-1:0]     cnt_r, cnt_n;
    logic [IW-1:0]     idx_r, idx_n;
    logic              out_valid_r, out_valid_n;
    logic [7:0]        out_data_r, out_data_n;
    logic              out_last_r, out_last_n;
    logic              in_ready_r, in_ready_n;
    logic              busy_r, busy_n;
    logic [BW+WIDTH-1:0] shift_s;
    logic [IW-1:0]     start_s;

    // One double-dabble step: adjust nibbles, then shift {bcd, bin} left.
    always_comb begin
        shift_s = {dabble_adj(bcd_r), bin_r} << 1;
    end

    // First digit index to transmit.
    always_comb begin
        start_s = IDX_TOP;
`ifdef BIN2ASCII_LZS_EN
        start_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] != 4'd0) begin
                start_s = IW'(i);
            end else begin
                start_s = start_s;
            end
        end
`else
        start_s = IDX_TOP;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_r;
        bin_n       = bin_r;
        bcd_n       = bcd_r;
        cnt_n       = cnt_r;
        idx_n       = idx_r;
        out_valid_n = out_valid_r;
        out_data_n  = out_data_r;
        out_last_n  = out_last_r;
        case (state_r)
            S_IDLE: begin
                out_valid_n = 1'b0;
                if (in_valid && in_ready_r) begin
                    bin_n   = in_data;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = S_CONV;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CONV: begin
                bcd_n = shift_s[BW+WIDTH-1:WIDTH];
                bin_n = shift_s[WIDTH-1:0];
                cnt_n = cnt_r + 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_n = S_PREP;
                end else begin
                    state_n = S_CONV;
                end
            end
            S_PREP: begin
                idx_n       = start_s;
                out_valid_n = 1'b1;
                out_data_n  = digit_char(bcd_r, start_s);
                out_last_n  = (start_s == '0) && !TERM_EN;
                state_n     = S_SEND;
            end
            S_SEND: begin
                if (out_valid_r && out_ready) begin
                    if (out_last_r) begin
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        state_n     = S_IDLE;
                    end else if (idx_r == '0) begin
                        // Digits exhausted but not last: the terminator follows.
                        out_data_n = TERM_CHAR;
                        out_last_n = 1'b1;
                    end else begin
                        idx_n      = idx_r - 1'b1;
                        out_data_n = digit_char(bcd_r, idx_r - 1'b1);
                        out_last_n = (idx_r == IW'(1)) && !TERM_EN;
                    end
                end else begin
                    state_n = S_SEND;
                end
            end
            default: begin
                state_n     = S_IDLE;
                out_valid_n = 1'b0;
                out_last_n  = 1'b0;
            end
        endcase
        in_ready_n = (state_n == S_IDLE);
        busy_n     = !in_ready_n;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            bin_r       <= '0;
            bcd_r       <= '0;
            cnt_r       <= '0;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            bin_r       <= bin_n;
            bcd_r       <= bcd_n;
            cnt_r       <= cnt_n;
            idx_r       <= idx_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            out_last_r  <= out_last_n;
            in_ready_r  <= in_ready_n;
            busy_r      <= busy_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_bin2ascii_str.sv
// Directed self-checking bench for bin2ascii_str (default parameters).
module tb_bin2ascii_str;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bin2ascii_str dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accept edge.
    task automatic wait_first();
        int lat;
        lat = 0;
        out_ready = 1'b0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 17);
    endtask

    // Receive n characters of exp; rnd selects 50% random out_ready.
    task automatic recv(input string exp, input int n, input bit rnd);
        int i, guard;
        bit stalled, rdy;
        logic [7:0] held, want;
        i = 0; guard = 0; stalled = 1'b0; held = 8'h00;
        while (i < n && guard < 500) begin
            if (stalled && out_valid) chk("stable_while_stalled", out_data, held);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
                want = 8'(exp[i]);
                chk("char", out_data, want);
                chk("last", out_last, (i == exp.len() - 1) ? 1 : 0);
                i++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_data;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        chk("chars_received", i, n);
        out_ready = 1'b0;
        if (n == exp.len()) begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 1);
        end
    endtask

    task automatic send_word(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        chk("in_ready_before_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        wait_first();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_word(16'd12345);
        recv("12345\n", 6, 1'b0);

        send_word(16'd0);
`ifdef BIN2ASCII_LZS_EN
        recv("0\n", 2, 1'b0);
`else
        recv("00000\n", 6, 1'b0);
`endif

        send_word(16'd65535);
        recv("65535\n", 6, 1'b0);

        send_word(16'd7);
`ifdef BIN2ASCII_LZS_EN
        recv("7\n", 2, 1'b0);
`else
        recv("00007\n", 6, 1'b0);
`endif

        send_word(16'd40960);
        recv("40960\n", 6, 1'b1);

        // Busy rejection: 999 stays presented while 321 is processed.
        in_valid = 1'b1;
        in_data  = 16'd321;
        chk("in_ready_before_321", in_ready, 1);
        @(negedge clk);
        in_data = 16'd999;
        chk("in_ready_busy", in_ready, 0);
        wait_first();
        chk("in_ready_send", in_ready, 0);
`ifdef BIN2ASCII_LZS_EN
        recv("321\n", 4, 1'b0);
`else
        recv("00321\n", 6, 1'b0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_999_accepted", busy, 1);
        wait_first();
`ifdef BIN2ASCII_LZS_EN
        recv("999\n", 4, 1'b0);
`else
        recv("00999\n", 6, 1'b0);
`endif

        // Reset in the middle of a string.
        send_word(16'd54321);
        recv("54321\n", 2, 1'b0);
        chk("third_char_pending", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(16'd42);
`ifdef BIN2ASCII_LZS_EN
        recv("42\n", 3, 1'b0);
`else
        recv("00042\n", 6, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
